dash_charge_controller: RTL and testbench

Single-clock dash input controller. Edge-detects the dash button on a slow sample tick and tracks a parametrised number of dash charges, refilled when grounded. Resolves an 8-way dash direction from the d-pad and facing, then issues a fixed-length dash_trigger window followed by a cooldown. Sits between the board buttons and the dash_leds effect and player physics.

---
 rtl/dash_charge_controller.sv | 152 +++++++++++++++
 tb/tb_dash_charge_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dash_charge_controller.sv
// Dash input controller: ticked button edge detect, charge tracking, 8-way direction latch,
// trigger window and cooldown. Define DASH_BUFFER_EN for a one-deep request buffer while busy.
module dash_charge_controller #(
    parameter int MAX_CHARGES     = 2,
    parameter int TRIGGER_CYCLES  = 5_000_000,
    parameter int COOLDOWN_CYCLES = 10_000_000,
    parameter int TIMER_W         = 24,
    localparam int CW             = $clog2(MAX_CHARGES + 1)
) (
    input  logic          basys_3_clock,
    input  logic          reset,
    input  logic          sample_tick,
    input  logic          leftBtn,
    input  logic          rightBtn,
    input  logic          upBtn,
    input  logic          downBtn,
    input  logic          dashBtn,
    input  logic          grounded,
    output logic          dash_trigger,
    output logic [2:0]    dash_dir,
    output logic          player_facing_left,
    output logic [CW-1:0] charges,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, DASH, COOLDOWN} state_t;

    localparam logic [CW-1:0]      FULL      = CW'(MAX_CHARGES);
    localparam logic [TIMER_W-1:0] TRIG_LOAD = TIMER_W'(TRIGGER_CYCLES - 1);
    localparam logic [TIMER_W-1:0] COOL_LOAD =
        TIMER_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               dash_prev;
    logic               req;
    logic               launch;
    logic               can_dash;
    logic [2:0]         dir_next;
    logic               h_r, h_l, v_u, v_d;

    assign req      = sample_tick & dashBtn & ~dash_prev;
    assign can_dash = (charges != '0) | grounded;

`ifdef DASH_BUFFER_EN
    logic dash_buf;

    // Any IDLE cycle consumes the buffer, whether or not a charge was available.
    always_ff @(posedge basys_3_clock) begin
        if (reset)
            dash_buf <= 1'b0;
        else if (state != IDLE) begin
            if (req)
                dash_buf <= 1'b1;
        end else
            dash_buf <= 1'b0;
    end

    assign launch = req | dash_buf;
`else
    assign launch = req;
`endif

    // Opposing buttons cancel on each axis.
    always_comb begin
        h_r = rightBtn & ~leftBtn;
        h_l = leftBtn & ~rightBtn;
        v_u = upBtn & ~downBtn;
        v_d = downBtn & ~upBtn;
        case ({h_r, h_l, v_u, v_d})
            4'b1000: dir_next = 3'd0;
            4'b1010: dir_next = 3'd1;
            4'b0010: dir_next = 3'd2;
            4'b0110: dir_next = 3'd3;
            4'b0100: dir_next = 3'd4;
            4'b0101: dir_next = 3'd5;
            4'b0001: dir_next = 3'd6;
            4'b1001: dir_next = 3'd7;
            default: dir_next = player_facing_left ? 3'd4 : 3'd0;
        endcase
    end

    always_ff @(posedge basys_3_clock) begin
        if (reset) begin
            dash_prev          <= 1'b1;
            player_facing_left <= 1'b0;
        end else begin
            if (sample_tick)
                dash_prev <= dashBtn;
            if (leftBtn & ~rightBtn)
                player_facing_left <= 1'b1;
            else if (rightBtn & ~leftBtn)
                player_facing_left <= 1'b0;
        end
    end

    always_ff @(posedge basys_3_clock) begin
        if (reset) begin
            state        <= IDLE;
            dash_trigger <= 1'b0;
            dash_dir     <= 3'd0;
            busy         <= 1'b0;
            charges      <= FULL;
            timer        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch && can_dash) begin
                        state        <= DASH;
                        dash_trigger <= 1'b1;
                        busy         <= 1'b1;
                        dash_dir     <= dir_next;
                        timer        <= TRIG_LOAD;
                        charges      <= (grounded ? FULL : charges) - CW'(1);
                    end else if (grounded) begin
                        charges <= FULL;
                    end
                end
                DASH: begin
                    if (timer == '0) begin
                        dash_trigger <= 1'b0;
                        if (COOLDOWN_CYCLES > 0) begin
                            state <= COOLDOWN;
                            timer <= COOL_LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                COOLDOWN: begin
                    if (grounded)
                        charges <= FULL;
                    if (timer == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    dash_trigger <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dash_charge_controller.sv
// Bench for dash_charge_controller: directed scenarios plus random button traffic, all steps
// checked against a busy-countdown reference model.
module tb_dash_charge_controller;

    localparam int MAXC = 2;
    localparam int TRIG = 4;
    localparam int COOL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       leftBtn = 1'b0, rightBtn = 1'b0, upBtn = 1'b0, downBtn = 1'b0;
    logic       dashBtn = 1'b0, grounded = 1'b0;
    logic       dash_trigger;
    logic [2:0] dash_dir;
    logic       player_facing_left;
    logic [1:0] charges;
    logic       busy;

    dash_charge_controller #(
        .MAX_CHARGES(MAXC), .TRIGGER_CYCLES(TRIG), .COOLDOWN_CYCLES(COOL), .TIMER_W(24)
    ) dut (
        .basys_3_clock(clk), .reset(reset), .sample_tick(sample_tick),
        .leftBtn(leftBtn), .rightBtn(rightBtn), .upBtn(upBtn), .downBtn(downBtn),
        .dashBtn(dashBtn), .grounded(grounded),
        .dash_trigger(dash_trigger), .dash_dir(dash_dir),
        .player_facing_left(player_facing_left), .charges(charges), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0, cyc = 0, tick_period = 10;

    // Model: m_rem counts remaining busy cycles; the first TRIG of them are the trigger window.
    bit m_prev = 1'b1, m_face = 1'b0, m_buf = 1'b0;
    int m_rem = 0, m_chg = MAXC, m_dir = 0;
    int dir_tab[3][3] = '{'{5, 4, 3}, '{6, 0, 2}, '{7, 0, 1}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit req, launch;
        int hx, vy, dir;
        if (reset) begin
            m_prev = 1'b1; m_face = 1'b0; m_buf = 1'b0;
            m_rem = 0; m_chg = MAXC; m_dir = 0;
        end else begin
            req = sample_tick && dashBtn && !m_prev;
            if (sample_tick) m_prev = dashBtn;
            hx = int'(rightBtn) - int'(leftBtn);
            vy = int'(upBtn) - int'(downBtn);
            dir = (hx == 0 && vy == 0) ? (m_face ? 4 : 0) : dir_tab[hx + 1][vy + 1];
            if (m_rem > 0) begin
                if (m_rem <= COOL && grounded) m_chg = MAXC;
`ifdef DASH_BUFFER_EN
                if (req) m_buf = 1'b1;
`endif
                m_rem--;
            end else begin
                launch = req || m_buf;
                m_buf = 1'b0;
                if (launch && (m_chg > 0 || grounded)) begin
                    m_chg = (grounded ? MAXC : m_chg) - 1;
                    m_dir = dir;
                    m_rem = TRIG + COOL;
                end else if (grounded) begin
                    m_chg = MAXC;
                end
            end
            if (hx < 0) m_face = 1'b1;
            else if (hx > 0) m_face = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        sample_tick = (cyc % tick_period == 0);
        check("trigger", dash_trigger, m_rem > COOL);
        check("busy", busy, m_rem > 0);
        check("dir", dash_dir, m_dir);
        check("charges", charges, m_chg);
        check("facing", player_facing_left, m_face);
    endtask

    task automatic run(input int n, output int hi, output int rises, output int bz);
        logic p;
        hi = 0; rises = 0; bz = 0; p = dash_trigger;
        repeat (n) begin
            step();
            if (dash_trigger) hi++;
            if (dash_trigger && !p) rises++;
            if (busy) bz++;
            p = dash_trigger;
        end
    endtask

    task automatic press(output int hi, output int rises, output int bz);
        int h2, r2, b2;
        dashBtn = 1'b1; run(15, hi, rises, bz);
        dashBtn = 1'b0; run(15, h2, r2, b2);
        hi += h2; rises += r2; bz += b2;
    endtask

    task automatic wait_trigger(input string tag);
        int n = 0;
        while (!dash_trigger && n < 30) begin step(); n++; end
        check(tag, dash_trigger, 1);
    endtask

    task automatic do_reset();
        int h, r, b;
        reset = 1'b1; step(); step();
        reset = 1'b0; run(20, h, r, b);
    endtask

    initial begin
        int hi, rises, bz, h2, r2, b2, n;

        // 1: reset state, then diagonal up-right airborne dash
        reset = 1'b1; step(); step();
        check("rst_trigger", dash_trigger, 0);
        check("rst_dir", dash_dir, 0);
        check("rst_charges", charges, MAXC);
        check("rst_busy", busy, 0);
        reset = 1'b0; run(20, hi, rises, bz);
        rightBtn = 1'b1; upBtn = 1'b1;
        press(hi, rises, bz);
        check("t1_trig_len", hi, TRIG);
        check("t1_busy_len", bz, TRIG + COOL);
        check("t1_dir", dash_dir, 1);
        check("t1_charges", charges, 1);
        rightBtn = 1'b0; upBtn = 1'b0;

        // 2: facing left, three presses, only two charges
        do_reset();
        leftBtn = 1'b1; step(); leftBtn = 1'b0; step();
        press(hi, rises, bz);
        check("t2_p1_len", hi, TRIG); check("t2_p1_dir", dash_dir, 4); check("t2_p1_chg", charges, 1);
        press(hi, rises, bz);
        check("t2_p2_len", hi, TRIG); check("t2_p2_dir", dash_dir, 4); check("t2_p2_chg", charges, 0);
        press(hi, rises, bz);
        check("t2_p3_len", hi, 0); check("t2_p3_chg", charges, 0);

        // 3: zero charges, grounded rises on the press tick
        n = 0;
        while (!sample_tick && n < 15) begin step(); n++; end
        grounded = 1'b1; dashBtn = 1'b1; step();
        grounded = 1'b0;
        check("t3_ground_fire", dash_trigger, 1);
        check("t3_ground_chg", charges, 1);
        dashBtn = 1'b0; run(30, hi, rises, bz);
        press(hi, rises, bz);
        check("t3_empty_chg", charges, 0);
        grounded = 1'b1; step();
        check("t3_refill", charges, MAXC);
        grounded = 1'b0;

        // 4: dash held through reset release must not fire
        dashBtn = 1'b1; reset = 1'b1; step(); step(); step();
        reset = 1'b0; run(50, hi, rises, bz);
        check("t4_held_no_dash", hi, 0);
        dashBtn = 1'b0; run(15, hi, rises, bz);
        dashBtn = 1'b1; run(15, hi, rises, bz);
        check("t4_repress_len", hi, TRIG);
        dashBtn = 1'b0; run(15, hi, rises, bz);

        // 5: cancelled horizontals give pure down; reset mid-dash
        do_reset();
        rightBtn = 1'b1; step();
        leftBtn = 1'b1; downBtn = 1'b1; dashBtn = 1'b1;
        wait_trigger("t5_fire");
        check("t5_dir", dash_dir, 6);
        reset = 1'b1; step();
        check("t5_rst_trigger", dash_trigger, 0);
        check("t5_rst_charges", charges, MAXC);
        reset = 1'b0; dashBtn = 1'b0; leftBtn = 1'b0; rightBtn = 1'b0; downBtn = 1'b0;
        run(20, hi, rises, bz);

        // 6: press during cooldown (faster tick so a full edge fits in cooldown)
        tick_period = 3;
        dashBtn = 1'b1;
        wait_trigger("t6_fire");
        dashBtn = 1'b0;
        n = 0;
        while (!(busy && !dash_trigger) && n < 30) begin step(); n++; end
        check("t6_in_cooldown", busy && !dash_trigger, 1);
        dashBtn = 1'b1; run(4, hi, rises, bz);
        dashBtn = 1'b0; run(30, h2, r2, b2);
`ifdef DASH_BUFFER_EN
        check("t6_second_dash", rises + r2, 1);
        check("t6_charges", charges, 0);
`else
        check("t6_second_dash", rises + r2, 0);
        check("t6_charges", charges, 1);
`endif
        tick_period = 10;

        // random traffic against the model
        do_reset();
        repeat (3000) begin
            if ($urandom % 8 == 0) dashBtn = ~dashBtn;
            if ($urandom % 16 == 0) {leftBtn, rightBtn, upBtn, downBtn} = 4'($urandom);
            if ($urandom % 20 == 0) grounded = ~grounded;
            reset = ($urandom % 400 == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
